// File: rtl/widen.sv
// ----------------------------------------------------------------------------
// widen -- sign-extending, left-justifying sample widener with a two-stage
// valid/ready pipeline.
//
// A narrow signed sample is placed in a wider signed word. Above it sit
// SHIFT copies of its sign bit. Below it sit L = OWID-SHIFT-IWID fill bits.
// The fill is all zeros, or, when MIDPOINT is set and L >= 2, a half-LSB
// pattern (100..0) that centres the value in the discarded range.
//
// Stage p1 captures the raw input sample. Stage p2 holds the widened output
// word. Each stage has its own valid flag. o_val and o_valid come straight
// from the p2 registers.
//
// Ports
//   i_clk    : clock; all state changes on its rising edge
//   i_reset  : asynchronous, active-high reset
//   i_ce     : clock enable; all state holds while low
//   i_valid  : i_val carries a sample this cycle
//   o_ready  : the block accepts i_val this cycle
//   i_val    : narrow signed sample, IWID bits
//   o_valid  : o_val holds a valid sample
//   i_ready  : downstream accepts o_val this cycle
//   o_val    : widened signed sample, OWID bits
//   o_count  : samples delivered downstream, modulo 2^16
// ----------------------------------------------------------------------------
module widen #(
    parameter int IWID     = 8,
    parameter int OWID     = 16,
    parameter int SHIFT    = 0,
    parameter int MIDPOINT = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic signed [IWID-1:0] i_val,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [OWID-1:0] o_val,
    output logic [15:0]            o_count
);

    // Number of fill bits below the input field.
    localparam int L        = OWID - SHIFT - IWID;
    localparam int FILL_BIT = (L >= 2) ? (L - 1) : 0;
    localparam logic [OWID-1:0] FILL =
        ((MIDPOINT != 0) && (L >= 2)) ? (OWID'(1) << FILL_BIT) : '0;

    generate
        if (OWID < IWID + SHIFT) begin : g_bad_widths
            $fatal(1, "widen: OWID must be at least IWID+SHIFT");
        end
    endgenerate

    // Sign-extending to OWID and then shifting left by L leaves exactly SHIFT
    // sign copies above the sample and L zero bits below it. OR-ing in the
    // constant then sets the optional half-LSB fill bit.
    function automatic logic signed [OWID-1:0] widen_f(input logic signed [IWID-1:0] v);
        logic signed [OWID-1:0] ext;
        ext = OWID'(v);
        return (ext <<< L) | $signed(FILL);
    endfunction

    logic                   r_vld_p1;
    logic signed [IWID-1:0] r_val_p1;
    logic                   r_vld_p2;
    logic signed [OWID-1:0] r_val_p2;
    logic [15:0]            r_count;

    logic w_xfer_out;
    logic w_adv_p2;
    logic w_move_p1_p2;
    logic w_adv_p1;
    logic w_xfer_in;

    // p2 may load when it is empty or when its sample leaves this cycle.
    // p1 may load when it is empty or when its sample moves into p2.
    // This chain lets the pipeline run at full rate without a skid buffer.
    assign w_xfer_out   = r_vld_p2 & i_ready & i_ce;
    assign w_adv_p2     = i_ce & (~r_vld_p2 | w_xfer_out);
    assign w_move_p1_p2 = r_vld_p1 & w_adv_p2;
    assign w_adv_p1     = i_ce & (~r_vld_p1 | w_move_p1_p2);
    assign o_ready      = w_adv_p1 & ~i_reset;
    assign w_xfer_in    = i_valid & o_ready;

    // ---- stage p1: capture the raw input sample ----
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld_p1 <= 1'b0;
            r_val_p1 <= '0;
        end else begin
            if (w_adv_p1) begin
                r_vld_p1 <= i_valid;
            end
            if (w_xfer_in) begin
                r_val_p1 <= i_val;
            end
        end
    end

    // ---- stage p2: widened output register and delivery counter ----
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld_p2 <= 1'b0;
            r_val_p2 <= '0;
            r_count  <= 16'd0;
        end else begin
            if (w_adv_p2) begin
                r_vld_p2 <= r_vld_p1;
            end
            if (w_move_p1_p2) begin
                r_val_p2 <= widen_f(r_val_p1);
            end
            if (w_xfer_out) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign o_valid = r_vld_p2;
    assign o_val   = r_val_p2;
    assign o_count = r_count;

endmodule

// File: tb/tb_widen.sv
module tb_widen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic        vld = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  val = 8'h00;

    logic        o_ready_a, o_valid_a, o_ready_b, o_valid_b;
    logic [15:0] o_val_a, o_val_b, o_count_a, o_count_b;

    always #5 clk = ~clk;

    widen #(.IWID(8), .OWID(16), .SHIFT(0), .MIDPOINT(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .o_ready(o_ready_a),
        .i_val(val), .o_valid(o_valid_a), .i_ready(rdy), .o_val(o_val_a), .o_count(o_count_a)
    );

    widen #(.IWID(8), .OWID(16), .SHIFT(2), .MIDPOINT(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .o_ready(o_ready_b),
        .i_val(val), .o_valid(o_valid_b), .i_ready(rdy), .o_val(o_val_b), .o_count(o_count_b)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  q[$];
    logic [15:0] cnt_m = 16'd0;
    bit          last_in = 1'b0;

    typedef struct {
        logic [7:0]  v;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Widened value as an integer: sample times 2^L, plus half an LSB of the
    // new word when midpoint fill applies, truncated to 16 bits.
    function automatic logic [15:0] model(input logic [7:0] v, input int shift, input bit mid);
        int l;
        int r;
        l = 16 - shift - 8;
        r = int'($signed(v));
        r = r * (1 << l);
        if (mid && l >= 2) r = r + (1 << (l - 1));
        return r[15:0];
    endfunction

    // One clock: check and score the handshake just before the edge, then
    // step past the edge.
    task automatic cycle();
        bit          exp_rdy, in_x, out_x, ce_s;
        logic [15:0] hold_a, hold_b;
        logic        hold_va;
        logic [7:0]  v;
        @(negedge clk);
        ce_s    = ce;
        exp_rdy = ce && !rst && (q.size() < 2 || rdy);
        chk("o_ready_a", o_ready_a, exp_rdy);
        chk("o_ready_b", o_ready_b, exp_rdy);
        chk("o_count", o_count_a, cnt_m);
        if (q.size() == 0) chk("idle o_valid", o_valid_a, 0);
        in_x  = vld && o_ready_a;
        out_x = o_valid_a && rdy && ce;
        if (out_x) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious output: got 0x%0h expected none", o_val_a);
            end else begin
                v = q.pop_front();
                chk("out value a", o_val_a, model(v, 0, 1'b0));
                chk("out value b", o_val_b, model(v, 2, 1'b1));
                cnt_m = cnt_m + 16'd1;
            end
        end
        if (in_x) q.push_back(val);
        last_in = in_x;
        hold_a  = o_val_a;
        hold_b  = o_val_b;
        hold_va = o_valid_a;
        @(posedge clk);
        #1;
        if (!ce_s) begin
            chk("ce0 hold o_val_a", o_val_a, hold_a);
            chk("ce0 hold o_val_b", o_val_b, hold_b);
            chk("ce0 hold o_valid", o_valid_a, hold_va);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("reset o_valid", o_valid_a, 0);
        chk("reset o_val", o_val_a, 0);
        chk("reset o_count", o_count_a, 0);
        chk("reset o_ready", o_ready_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        cnt_m = 16'd0;
    endtask

    initial begin
        int acc;
        int n;

        tbl[0] = '{8'h81, 16'h8100, 16'hE060};
        tbl[1] = '{8'h7F, 16'h7F00, 16'h1FE0};
        tbl[2] = '{8'hC0, 16'hC000, 16'hF020};
        tbl[3] = '{8'h00, 16'h0000, 16'h0020};
        tbl[4] = '{8'h80, 16'h8000, 16'hE020};
        tbl[5] = '{8'hFF, 16'hFF00, 16'hFFE0};
        tbl[6] = '{8'h01, 16'h0100, 16'h0060};

        do_reset();

        // Table: single samples, latency of two edges, field mapping.
        rdy = 1'b1;
        ce  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            val = tbl[i].v;
            vld = 1'b1;
            cycle();
            chk("table accept", last_in, 1);
            vld = 1'b0;
            chk("table lat1 o_valid", o_valid_a, 0);
            cycle();
            chk("table lat2 o_valid", o_valid_a, 1);
            chk("table o_val a", o_val_a, tbl[i].ea);
            chk("table o_val b", o_val_b, tbl[i].eb);
            cycle();
        end

        // Backpressure: fill both stages, hold, then drain in order.
        do_reset();
        rdy = 1'b0;
        vld = 1'b1;
        val = 8'd1;
        cycle();
        chk("bp accept 1", last_in, 1);
        val = 8'd2;
        cycle();
        chk("bp accept 2", last_in, 1);
        val = 8'd3;
        chk("bp full o_ready", o_ready_a, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp stall accept", last_in, 0);
            chk("bp stall o_val", o_val_a, 16'h0100);
            chk("bp stall o_valid", o_valid_a, 1);
        end
        rdy = 1'b1;
        cycle();
        chk("bp accept 3", last_in, 1);
        val = 8'd4;
        cycle();
        chk("bp accept 4", last_in, 1);
        vld = 1'b0;
        cycle();
        cycle();
        chk("bp o_count", o_count_a, 4);

        // Clock enable toggling under a continuous stream.
        do_reset();
        rdy = 1'b1;
        vld = 1'b1;
        val = 8'd10;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            ce = (c % 2 == 0);
            cycle();
            if (last_in) begin
                acc++;
                val = val + 8'd1;
            end
        end
        chk("ce half-rate accepts", acc, 20);
        chk("ce delivered+inflight", 32'(o_count_a) + q.size(), 20);
        vld = 1'b0;
        ce  = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("ce drained o_count", o_count_a, 20);

        // Reset with two samples in flight.
        rdy = 1'b0;
        vld = 1'b1;
        val = 8'h55;
        cycle();
        val = 8'h66;
        cycle();
        vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midreset o_valid", o_valid_a, 0);
        chk("midreset o_count", o_count_a, 0);
        chk("midreset o_val", o_val_a, 0);
        chk("midreset o_ready", o_ready_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        cnt_m = 16'd0;
        rdy = 1'b1;
        val = 8'h33;
        vld = 1'b1;
        cycle();
        chk("post-reset accept", last_in, 1);
        vld = 1'b0;
        chk("post-reset lat1", o_valid_a, 0);
        cycle();
        chk("post-reset lat2", o_valid_a, 1);
        chk("post-reset o_val a", o_val_a, 16'h3300);
        chk("post-reset o_val b", o_val_b, 16'h0CE0);
        cycle();

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            vld = 1'($urandom_range(0, 1));
            val = 8'($urandom);
            rdy = (($urandom % 4) != 0);
            ce  = (($urandom % 8) != 0);
            cycle();
        end
        vld = 1'b0;
        rdy = 1'b1;
        ce  = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("random drained o_valid", o_valid_a, 0);

        // o_count wrap-around.
        do_reset();
        rdy = 1'b1;
        ce  = 1'b1;
        vld = 1'b1;
        val = 8'h12;
        n = 0;
        while (o_count_a != 16'hFFFF && n < 66000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wrap reach ffff", o_count_a, 16'hFFFF);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap hold ffff", o_count_a, 16'hFFFF);
        chk("wrap o_valid", o_valid_a, 1);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap to zero", o_count_a, 16'h0000);
        vld = 1'b0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
